// File: rtl/axi_rd_sram_slave_pkg.sv
// Shared AXI read-channel definitions: response codes, FSM states and field widths
// for the SRAM-backed read slave.
package axi_rd_sram_slave_pkg;

   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 64;
   localparam int unsigned AXI_LEN_W  = 8;
   localparam int unsigned AXI_RESP_W = 2;
   localparam int unsigned AXI_WADDR_W = AXI_ADDR_W - 3;

   // Wide enough for LATENCY-1 (max 14) plus a random extra of up to 7.
   localparam int unsigned CNT_W = 5;

   localparam logic [AXI_RESP_W-1:0] RRESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] RRESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DATA = 2'd2
   } rd_state_t;

endpackage

// File: rtl/axi_rd_sram_slave_sram_model.sv
// DEPTH x 64 SRAM model: one registered synchronous read port, one write port.
// A same-cycle read and write of one index returns the old contents.
module sram_model
   import axi_rd_sram_slave_pkg::*;
#(
   parameter int unsigned DEPTH = 4096,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rd_en,
   input  logic [IDX_W-1:0]      i_rd_idx,
   output logic [AXI_DATA_W-1:0] o_rd_data,
   input  logic                  i_wr_en,
   input  logic [IDX_W-1:0]      i_wr_idx,
   input  logic [AXI_DATA_W-1:0] i_wr_data
);

   logic [AXI_DATA_W-1:0] r_mem [DEPTH];
   logic [AXI_DATA_W-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_idx];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_rd_sram_slave.sv
// AXI4 read-channel slave over a 64-bit SRAM with programmable first-beat latency.
// Optional build macro RANDOM_DELAY_EN adds 0..7 LFSR-chosen extra wait cycles per burst.
module axi_rd_sram_slave
   import axi_rd_sram_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned LATENCY   = 2,
   localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   input  logic [AXI_ADDR_W-1:0] ARADDR,
   input  logic [AXI_LEN_W-1:0]  ARLEN,
   input  logic [2:0]            ARPROT,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic [AXI_DATA_W-1:0] RDATA,
   output logic [AXI_RESP_W-1:0] RRESP,
   output logic                  RLAST,
   input  logic                  bd_wr_en,
   input  logic [IDX_W-1:0]      bd_wr_idx,
   input  logic [AXI_DATA_W-1:0] bd_wr_data
);

   rd_state_t r_state, w_state_nxt;

   logic                   r_arready, r_rvalid, r_rlast, r_rdata_ok;
   logic [AXI_RESP_W-1:0]  r_rresp;
   logic [AXI_WADDR_W-1:0] r_waddr;
   logic [AXI_LEN_W-1:0]   r_len, r_beat;
   logic [CNT_W-1:0]       r_cnt;

   logic                   w_ar_hs, w_r_hs, w_issue, w_issue_hit;
   logic [AXI_WADDR_W-1:0] w_issue_waddr;
   logic [AXI_LEN_W-1:0]   w_issue_beat;
   logic [AXI_ADDR_W-1:0]  w_issue_byte, w_issue_off;
   logic [CNT_W-1:0]       w_wait_cnt;
   logic [AXI_DATA_W-1:0]  w_sram_q;
   logic                   w_unused;

`ifdef RANDOM_DELAY_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) r_lfsr <= 16'hACE1;
      else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   assign w_wait_cnt = CNT_W'(LATENCY - 1) + CNT_W'(r_lfsr[2:0]);
`else
   assign w_wait_cnt = CNT_W'(LATENCY - 1);
`endif

   assign w_ar_hs = ARVALID && r_arready && (r_state == S_IDLE);
   assign w_r_hs  = r_rvalid && RREADY;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // WAIT is always entered so that a zero count issues the beat-0 read one
   // cycle after the handshake, giving RVALID exactly LATENCY edges later.
   always_comb begin
      w_state_nxt   = r_state;
      w_issue       = 1'b0;
      w_issue_waddr = r_waddr;
      w_issue_beat  = r_beat;
      case (r_state)
         S_IDLE: if (w_ar_hs) w_state_nxt = S_WAIT;
         S_WAIT: if (r_cnt == '0) begin
            w_issue     = 1'b1;
            w_state_nxt = S_DATA;
         end
         S_DATA: if (w_r_hs) begin
            if (r_rlast) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_issue       = 1'b1;
               w_issue_waddr = r_waddr + 1'b1;
               w_issue_beat  = r_beat + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_issue_byte = {w_issue_waddr, 3'b000};
   assign w_issue_off  = w_issue_byte - BASE_ADDR;
   assign w_issue_hit  = (w_issue_byte >= BASE_ADDR) && ({3'b000, w_issue_off[31:3]} < 32'(DEPTH));

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rlast    <= 1'b0;
         r_rdata_ok <= 1'b0;
         r_rresp    <= RRESP_OKAY;
         r_waddr    <= '0;
         r_len      <= '0;
         r_beat     <= '0;
         r_cnt      <= '0;
      end else begin
         r_arready <= (w_state_nxt == S_IDLE);
         if (w_ar_hs) begin
            r_waddr <= ARADDR[31:3];
            r_len   <= ARLEN;
            r_beat  <= '0;
            r_cnt   <= w_wait_cnt;
         end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_issue) begin
            r_waddr    <= w_issue_waddr;
            r_beat     <= w_issue_beat;
            r_rvalid   <= 1'b1;
            r_rlast    <= (w_issue_beat == r_len);
            r_rdata_ok <= w_issue_hit;
            r_rresp    <= w_issue_hit ? RRESP_OKAY : RRESP_SLVERR;
         end else if (w_r_hs) begin
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rdata_ok <= 1'b0;
            r_rresp    <= RRESP_OKAY;
         end
      end
   end

   sram_model #(.DEPTH(DEPTH)) u_sram (
      .i_clk     (ACLK),
      .i_rd_en   (w_issue && w_issue_hit),
      .i_rd_idx  (w_issue_off[IDX_W+2:3]),
      .o_rd_data (w_sram_q),
      .i_wr_en   (bd_wr_en),
      .i_wr_idx  (bd_wr_idx),
      .i_wr_data (bd_wr_data)
   );

   assign ARREADY = r_arready;
   assign RVALID  = r_rvalid;
   assign RLAST   = r_rlast;
   assign RRESP   = r_rresp;
   assign RDATA   = r_rdata_ok ? w_sram_q : '0;

   assign w_unused = ^{ARPROT, ARADDR[2:0], w_issue_off[2:0]};

endmodule

// File: tb/tb_axi_rd_sram_slave.sv
// Randomised bench for axi_rd_sram_slave against an array-based memory model.
`timescale 1ns/1ps
module tb_axi_rd_sram_slave;
   import axi_rd_sram_slave_pkg::*;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned DEPTH = 4096;
   localparam int unsigned LAT   = 2;
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] ARADDR = '0;
   logic [7:0]  ARLEN = '0;
   logic [2:0]  ARPROT = '0;
   logic        RVALID;
   logic        RREADY = 1'b0;
   logic [63:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        bd_wr_en = 1'b0;
   logic [IDX_W-1:0] bd_wr_idx = '0;
   logic [63:0] bd_wr_data = '0;

   always #5 ACLK = ~ACLK;

   axi_rd_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARPROT(ARPROT),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .bd_wr_en(bd_wr_en), .bd_wr_idx(bd_wr_idx), .bd_wr_data(bd_wr_data)
   );

   logic [63:0] mem_model [DEPTH];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // {resp, data} that the memory map promises for a byte address.
   function automatic logic [65:0] ref_beat(input logic [31:0] a);
      logic [31:0] aligned;
      logic [31:0] idx;
      aligned = a & ~32'd7;
      if (aligned < BASE) return {RRESP_SLVERR, 64'h0};
      idx = (aligned - BASE) / 8;
      if (idx >= DEPTH) return {RRESP_SLVERR, 64'h0};
      return {RRESP_OKAY, mem_model[idx]};
   endfunction

   task automatic bd_write(input int idx, input logic [63:0] d);
      @(negedge ACLK);
      bd_wr_en = 1'b1; bd_wr_idx = IDX_W'(idx); bd_wr_data = d;
      @(negedge ACLK);
      bd_wr_en = 1'b0;
      mem_model[idx] = d;
   endtask

   task automatic check_latency(input int lat);
`ifdef RANDOM_DELAY_EN
      check_val("latency_range", 64'((lat >= int'(LAT)) && (lat <= int'(LAT) + 7)), 64'd1);
`else
      check_val("latency", 64'(lat), 64'(LAT));
`endif
   endtask

   // mode 0: RREADY always high; 1: 1,0,0,1,0,1 pattern; 2: random.
   // collide: backdoor-overwrite the beat-0 word on the edge its read is issued.
   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int mode,
                          input bit collide, output int lat);
      bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int          n, beat, guard, k, cidx;
      logic [65:0] e;
      logic [63:0] cdata;
      lat = -1;
      cidx = int'((addr - BASE) / 8);
      cdata = collide ? ~mem_model[cidx] : 64'h0;
      @(negedge ACLK);
      ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARPROT = 3'($urandom);
      guard = 0;
      while (ARREADY !== 1'b1 && guard < 20) begin
         @(negedge ACLK);
         guard++;
      end
      check_val("arready_idle", 64'(ARREADY), 64'd1);
      if (ARREADY !== 1'b1) begin
         ARVALID = 1'b0;
         return;
      end
      @(negedge ACLK);
      // Master keeps ARVALID high with a junk address; the slave must ignore it.
      ARADDR = 32'($urandom);
      check_val("arready_busy", 64'(ARREADY), 64'd0);
      n = 0; beat = 0; k = 0;
      while (beat <= int'(len) && n < 2000) begin
         if (collide && n == int'(LAT) - 1) begin
            bd_wr_en = 1'b1; bd_wr_idx = IDX_W'(cidx); bd_wr_data = cdata;
         end else begin
            bd_wr_en = 1'b0;
         end
         if (RVALID === 1'b1) begin
            ARVALID = 1'b0;
            if (lat < 0) lat = n;
            e = ref_beat(addr + 32'(beat) * 32'd8);
            check_val("rdata", RDATA, e[63:0]);
            check_val("rresp", 64'(RRESP), 64'(e[65:64]));
            check_val("rlast", 64'(RLAST), 64'(beat == int'(len)));
            case (mode)
               0:       RREADY = 1'b1;
               1:       RREADY = pat[k % 6];
               default: RREADY = 1'($urandom_range(0, 1));
            endcase
            k++;
            if (RREADY) beat++;
         end else begin
            RREADY = (mode == 0);
            if (lat >= 0) check_val("rvalid_held", 64'(RVALID), 64'd1);
         end
         @(negedge ACLK);
         n++;
      end
      bd_wr_en = 1'b0;
      ARVALID = 1'b0;
      RREADY = 1'b0;
      if (beat <= int'(len)) check_val("burst_timeout", 64'(beat), 64'(len) + 64'd1);
      check_val("rvalid_after", 64'(RVALID), 64'd0);
      check_val("arready_after", 64'(ARREADY), 64'd1);
      if (collide) mem_model[cidx] = cdata;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, seen, idx, len, mode;

      repeat (3) @(negedge ACLK);
      check_val("rst_arready", 64'(ARREADY), 64'd0);
      check_val("rst_rvalid",  64'(RVALID),  64'd0);
      check_val("rst_rlast",   64'(RLAST),   64'd0);
      check_val("rst_rresp",   64'(RRESP),   64'd0);
      check_val("rst_rdata",   RDATA,        64'd0);
      ARESETn = 1'b1;

      bd_write(0, 64'h1122_3344_5566_7788);
      for (int i = 1; i < 64; i++) bd_write(i, {$urandom, $urandom});
      for (int i = DEPTH - 4; i < DEPTH; i++) bd_write(i, {$urandom, $urandom});

      // Single beat at word 0, then bursts with full and throttled RREADY.
      do_read(BASE, 8'd0, 0, 1'b0, lat);
      check_latency(lat);
      do_read(BASE + 32'h10, 8'd3, 0, 1'b0, lat);
      check_latency(lat);
      do_read(BASE + 32'h10, 8'd3, 1, 1'b0, lat);
      check_latency(lat);

      // Out-of-range below and above the window, a burst crossing the top, then OKAY again.
      do_read(32'h7FFF_FFF8, 8'd0, 0, 1'b0, lat);
      do_read(BASE + 32'(DEPTH) * 32'd8, 8'd0, 0, 1'b0, lat);
      do_read(BASE + 32'(DEPTH - 2) * 32'd8, 8'd3, 2, 1'b0, lat);
      do_read(BASE + 32'h8, 8'd0, 0, 1'b0, lat);

`ifndef RANDOM_DELAY_EN
      do_read(BASE + 32'h18, 8'd0, 0, 1'b1, lat);
      do_read(BASE + 32'h18, 8'd0, 0, 1'b0, lat);
`endif

      // Reset while beat 2 of an 8-beat burst is on the bus.
      @(negedge ACLK);
      ARVALID = 1'b1; ARADDR = BASE; ARLEN = 8'd7;
      n = 0;
      while (ARREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
      @(negedge ACLK);
      ARVALID = 1'b0; RREADY = 1'b1;
      n = 0; seen = 0;
      while (seen < 2 && n < 100) begin
         if (RVALID === 1'b1) seen++;
         @(negedge ACLK);
         n++;
      end
      check_val("mid_beat2_valid", 64'(RVALID), 64'd1);
      check_val("mid_beat2_data", RDATA, mem_model[2]);
      ARESETn = 1'b0;
      @(negedge ACLK);
      check_val("mid_rst_rvalid", 64'(RVALID), 64'd0);
      check_val("mid_rst_arready", 64'(ARREADY), 64'd0);
      ARESETn = 1'b1;
      @(negedge ACLK);
      check_val("post_rst_arready", 64'(ARREADY), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check_val("post_rst_quiet", 64'(RVALID), 64'd0);
         @(negedge ACLK);
      end
      RREADY = 1'b0;
      do_read(BASE + 32'h28, 8'd1, 0, 1'b0, lat);
      check_latency(lat);

      // Random single-beat reads with occasional out-of-range addresses.
      for (int i = 0; i < 100; i++) begin
         idx = int'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) idx = int'(DEPTH) + int'($urandom_range(0, 3));
         do_read(BASE + 32'(idx) * 32'd8, 8'd0, 2, 1'b0, lat);
         check_latency(lat);
      end

      // Random short bursts in every RREADY mode.
      for (int i = 0; i < 20; i++) begin
         len  = int'($urandom_range(0, 7));
         idx  = int'($urandom_range(0, 56));
         mode = int'($urandom_range(0, 2));
         do_read(BASE + 32'(idx) * 32'd8, 8'(len), mode, 1'b0, lat);
         check_latency(lat);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
